// File: rtl/safe_box_pkg.sv
// Shared definitions for the safe box controller: FSM state encoding and keypad codes.
package safe_box_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED = 2'd0,
        ST_OPEN   = 2'd1,
        ST_SET_PW = 2'd2,
        ST_ALARM  = 2'd3
    } box_state_t;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;
    localparam logic [3:0] KEY_LOCK  = 4'hC;
    localparam logic [3:0] KEY_SETPW = 4'hD;

    localparam logic [2:0] ENTRY_DIGITS = 3'd4;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/safe_box_ctrl_if.sv
// Keypad strobe and status bundle between the keypad/display side and the safe box controller.
interface safe_box_ctrl_if;

    logic       key_valid;
    logic [3:0] key_code;
    logic       state;
    logic       alarm;
    logic [1:0] err_cnt;
    logic [2:0] digit_cnt;

    modport master (
        output key_valid,
        output key_code,
        input  state,
        input  alarm,
        input  err_cnt,
        input  digit_cnt
    );

    modport slave (
        input  key_valid,
        input  key_code,
        output state,
        output alarm,
        output err_cnt,
        output digit_cnt
    );

endinterface

// File: rtl/safe_box_ctrl_pw_entry_buf.sv
// Four-digit BCD entry buffer: shifts new digits into the LSD, saturates at four digits.
module pw_entry_buf
    import safe_box_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        shift,
    input  logic        clear,
    input  logic [3:0]  digit,
    output logic [15:0] entry,
    output logic [2:0]  count
);

    // Clear wins over shift; a full buffer silently drops extra digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry <= 16'h0000;
            count <= 3'd0;
        end else if (clear) begin
            entry <= 16'h0000;
            count <= 3'd0;
        end else if (shift && count != ENTRY_DIGITS) begin
            entry <= {entry[11:0], digit};
            count <= count + 3'd1;
        end
    end

endmodule

// File: rtl/safe_box_ctrl.sv
// Safe box controller: password check, password change, alarm lockout and idle auto-relock.
module safe_box_ctrl
    import safe_box_pkg::*;
#(
    parameter logic [15:0] DEF_PW       = 16'h1234,
    parameter int          MAX_TRIES    = 3,
    parameter int          ALARM_CYCLES = 500000,
    parameter int          OPEN_TIMEOUT = 1000000
)(
    input  logic            clk,
    input  logic            rst,
    safe_box_ctrl_if.slave  bus
);

    localparam int AW = $clog2(ALARM_CYCLES + 1);
    localparam int IW = $clog2(OPEN_TIMEOUT + 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(OPEN_TIMEOUT - 1);
    localparam logic [1:0]    TRIES_MAX  = 2'(MAX_TRIES);

    box_state_t    fsm;
    logic          state_q;
    logic          alarm_q;
    logic [1:0]    err_q;
    logic [1:0]    err_next;
    logic [15:0]   password;
    logic [15:0]   entry;
    logic [2:0]    entry_cnt;
    logic [AW-1:0] alarm_cnt;
    logic [IW-1:0] idle_cnt;
    logic          key_digit;
    logic          key_enter;
    logic          key_clear;
    logic          key_lock;
    logic          key_setpw;
    logic          idle_expire;
    logic          entry_match;
    logic          buf_shift;
    logic          buf_clear;

    pw_entry_buf u_entry (
        .clk   (clk),
        .rst   (rst),
        .shift (buf_shift),
        .clear (buf_clear),
        .digit (bus.key_code),
        .entry (entry),
        .count (entry_cnt)
    );

    assign err_next      = err_q + 2'd1;
    assign bus.state     = state_q;
    assign bus.alarm     = alarm_q;
    assign bus.err_cnt   = err_q;
    assign bus.digit_cnt = entry_cnt;

    // Buffer is emptied on every attempt and on every way out of password entry.
    always_comb begin
        key_digit   = bus.key_valid && is_digit(bus.key_code);
        key_enter   = bus.key_valid && (bus.key_code == KEY_ENTER);
        key_clear   = bus.key_valid && (bus.key_code == KEY_CLEAR);
        key_lock    = bus.key_valid && (bus.key_code == KEY_LOCK);
        key_setpw   = bus.key_valid && (bus.key_code == KEY_SETPW);
        idle_expire = !bus.key_valid && (idle_cnt == IDLE_LAST);
        entry_match = (entry_cnt == ENTRY_DIGITS) && (entry == password);
        buf_shift   = 1'b0;
        buf_clear   = 1'b0;
        case (fsm)
            ST_LOCKED: begin
                buf_shift = key_digit;
                buf_clear = key_clear || key_enter;
            end
            ST_OPEN: begin
                buf_clear = key_clear || key_setpw || idle_expire;
            end
            ST_SET_PW: begin
                buf_shift = key_digit;
                buf_clear = key_clear || key_enter || key_lock || idle_expire;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= ST_LOCKED;
            state_q   <= 1'b0;
            alarm_q   <= 1'b0;
            err_q     <= 2'd0;
            password  <= DEF_PW;
            alarm_cnt <= '0;
            idle_cnt  <= '0;
        end else begin
            case (fsm)
                ST_LOCKED: begin
                    if (key_enter) begin
                        if (entry_match) begin
                            fsm      <= ST_OPEN;
                            state_q  <= 1'b1;
                            err_q    <= 2'd0;
                            idle_cnt <= '0;
                        end else if (err_next == TRIES_MAX) begin
                            fsm       <= ST_ALARM;
                            alarm_q   <= 1'b1;
                            err_q     <= TRIES_MAX;
                            alarm_cnt <= '0;
                        end else begin
                            err_q <= err_next;
                        end
                    end
                end
                // OPEN and SET_PW share the idle timer; any key restarts it.
                ST_OPEN: begin
                    if (bus.key_valid) begin
                        idle_cnt <= '0;
                        if (key_lock) begin
                            fsm     <= ST_LOCKED;
                            state_q <= 1'b0;
                        end else if (key_setpw) begin
                            fsm <= ST_SET_PW;
                        end
                    end else if (idle_expire) begin
                        fsm     <= ST_LOCKED;
                        state_q <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                ST_SET_PW: begin
                    if (bus.key_valid) begin
                        idle_cnt <= '0;
                        if (key_enter) begin
                            fsm <= ST_OPEN;
                            if (entry_cnt == ENTRY_DIGITS) begin
                                password <= entry;
                            end
                        end else if (key_lock) begin
                            fsm     <= ST_LOCKED;
                            state_q <= 1'b0;
                        end
                    end else if (idle_expire) begin
                        fsm     <= ST_LOCKED;
                        state_q <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                ST_ALARM: begin
                    if (alarm_cnt == ALARM_LAST) begin
                        fsm     <= ST_LOCKED;
                        alarm_q <= 1'b0;
                        err_q   <= 2'd0;
                    end else begin
                        alarm_cnt <= alarm_cnt + AW'(1);
                    end
                end
                default: begin
                    fsm     <= ST_LOCKED;
                    state_q <= 1'b0;
                    alarm_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_safe_box_ctrl.sv
// Directed scoreboard bench for safe_box_ctrl with short alarm and idle timeouts.
module tb_safe_box_ctrl;
    import safe_box_pkg::*;

    localparam int ALARM_CYCLES = 20;
    localparam int OPEN_TIMEOUT = 50;

    typedef struct {
        string      tag;
        logic [6:0] vec;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];

    safe_box_ctrl_if bus();

    safe_box_ctrl #(
        .DEF_PW       (16'h1234),
        .MAX_TRIES    (3),
        .ALARM_CYCLES (ALARM_CYCLES),
        .OPEN_TIMEOUT (OPEN_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic expect_out(input string tag, input bit st, input bit al, input int err, input int dc);
        exp_t e;
        e.tag = tag;
        e.vec = {st, al, 2'(err), 3'(dc)};
        sb.push_back(e);
    endtask

    task automatic check_output();
        exp_t       e;
        logic [6:0] obs;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("[TB] FAIL scoreboard: no expected entry queued");
            return;
        end
        e   = sb.pop_front();
        obs = {bus.state, bus.alarm, bus.err_cnt, bus.digit_cnt};
        assert (obs === e.vec) else begin
            errors++;
            $error("[TB] FAIL %s: observed st=%0b al=%0b err=%0d dig=%0d, expected st=%0b al=%0b err=%0d dig=%0d",
                   e.tag, obs[6], obs[5], obs[4:3], obs[2:0], e.vec[6], e.vec[5], e.vec[4:3], e.vec[2:0]);
        end
    endtask

    task automatic check_int(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Called at a negedge; the key is seen by exactly one posedge.
    task automatic press(input logic [3:0] code);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_code  = 4'hF;
    endtask

    task automatic apply_stimulus(input logic [3:0] code, input string tag,
                                  input bit st, input bit al, input int err, input int dc);
        expect_out(tag, st, al, err, dc);
        press(code);
        check_output();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        idle(2);
        expect_out("reset", 0, 0, 0, 0);
        check_output();
        rst = 1'b0;

        // Correct default password opens the safe.
        apply_stimulus(4'd1, "open_d1", 0, 0, 0, 1);
        apply_stimulus(4'd2, "open_d2", 0, 0, 0, 2);
        apply_stimulus(4'd3, "open_d3", 0, 0, 0, 3);
        apply_stimulus(4'd4, "open_d4", 0, 0, 0, 4);
        apply_stimulus(KEY_ENTER, "open_enter", 1, 0, 0, 0);
        apply_stimulus(4'd7, "open_digit_ignored", 1, 0, 0, 0);
        apply_stimulus(KEY_LOCK, "open_lock", 0, 0, 0, 0);

        // Three wrong attempts trigger the alarm.
        for (int t = 1; t <= 3; t++) begin
            apply_stimulus(4'd1, "wrong_d1", 0, 0, t - 1, 1);
            apply_stimulus(4'd2, "wrong_d2", 0, 0, t - 1, 2);
            apply_stimulus(4'd3, "wrong_d3", 0, 0, t - 1, 3);
            apply_stimulus(4'd5, "wrong_d5", 0, 0, t - 1, 4);
            apply_stimulus(KEY_ENTER, "wrong_enter", 0, (t == 3), t, 0);
        end
        apply_stimulus(4'd1, "alarm_digit", 0, 1, 3, 0);
        apply_stimulus(4'd2, "alarm_digit", 0, 1, 3, 0);
        apply_stimulus(KEY_CLEAR, "alarm_clear", 0, 1, 3, 0);
        apply_stimulus(KEY_ENTER, "alarm_enter", 0, 1, 3, 0);
        apply_stimulus(KEY_SETPW, "alarm_setpw", 0, 1, 3, 0);
        n = 5;
        while (bus.alarm && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_int("alarm_duration", n, ALARM_CYCLES);
        expect_out("alarm_exit", 0, 0, 0, 0);
        check_output();

        // Change password to 9876, then old password is rejected.
        apply_stimulus(KEY_SETPW, "lock_setpw_noop", 0, 0, 0, 0);
        apply_stimulus(4'd1, "pw_d1", 0, 0, 0, 1);
        apply_stimulus(4'd2, "pw_d2", 0, 0, 0, 2);
        apply_stimulus(4'd3, "pw_d3", 0, 0, 0, 3);
        apply_stimulus(4'd4, "pw_d4", 0, 0, 0, 4);
        apply_stimulus(KEY_ENTER, "pw_open", 1, 0, 0, 0);
        apply_stimulus(KEY_SETPW, "setpw", 1, 0, 0, 0);
        apply_stimulus(4'd9, "setpw_d9", 1, 0, 0, 1);
        apply_stimulus(4'd8, "setpw_d8", 1, 0, 0, 2);
        apply_stimulus(4'd7, "setpw_d7", 1, 0, 0, 3);
        apply_stimulus(4'd6, "setpw_d6", 1, 0, 0, 4);
        apply_stimulus(KEY_ENTER, "setpw_enter", 1, 0, 0, 0);
        apply_stimulus(KEY_SETPW, "setpw_short", 1, 0, 0, 0);
        apply_stimulus(4'd5, "setpw_short_d5", 1, 0, 0, 1);
        apply_stimulus(KEY_ENTER, "setpw_short_enter", 1, 0, 0, 0);
        apply_stimulus(KEY_LOCK, "relock", 0, 0, 0, 0);
        apply_stimulus(4'd1, "old_d1", 0, 0, 0, 1);
        apply_stimulus(4'd2, "old_d2", 0, 0, 0, 2);
        apply_stimulus(4'd3, "old_d3", 0, 0, 0, 3);
        apply_stimulus(4'd4, "old_d4", 0, 0, 0, 4);
        apply_stimulus(KEY_ENTER, "old_rejected", 0, 0, 1, 0);
        apply_stimulus(4'd9, "new_d9", 0, 0, 1, 1);
        apply_stimulus(4'd8, "new_d8", 0, 0, 1, 2);
        apply_stimulus(4'd7, "new_d7", 0, 0, 1, 3);
        apply_stimulus(4'd6, "new_d6", 0, 0, 1, 4);
        apply_stimulus(KEY_ENTER, "new_opens", 1, 0, 0, 0);

        // Idle auto-relock after OPEN_TIMEOUT cycles.
        idle(OPEN_TIMEOUT - 1);
        expect_out("idle_last_open", 1, 0, 0, 0);
        check_output();
        idle(1);
        expect_out("idle_relock", 0, 0, 0, 0);
        check_output();

        // A key one cycle before the timeout restarts the idle count.
        apply_stimulus(4'd9, "reopen_d9", 0, 0, 0, 1);
        apply_stimulus(4'd8, "reopen_d8", 0, 0, 0, 2);
        apply_stimulus(4'd7, "reopen_d7", 0, 0, 0, 3);
        apply_stimulus(4'd6, "reopen_d6", 0, 0, 0, 4);
        apply_stimulus(KEY_ENTER, "reopen", 1, 0, 0, 0);
        idle(OPEN_TIMEOUT - 2);
        apply_stimulus(4'd3, "idle_restart_key", 1, 0, 0, 0);
        idle(OPEN_TIMEOUT - 1);
        expect_out("restart_still_open", 1, 0, 0, 0);
        check_output();
        idle(1);
        expect_out("restart_relock", 0, 0, 0, 0);
        check_output();

        // Short entry, saturation and CLEAR.
        apply_stimulus(4'd1, "short_d1", 0, 0, 0, 1);
        apply_stimulus(4'd2, "short_d2", 0, 0, 0, 2);
        apply_stimulus(KEY_ENTER, "short_enter", 0, 0, 1, 0);
        for (int d = 1; d <= 5; d++) begin
            apply_stimulus(4'(d), "sat_digit", 0, 0, 1, (d > 4) ? 4 : d);
        end
        apply_stimulus(KEY_CLEAR, "clear", 0, 0, 1, 0);
        apply_stimulus(4'd9, "sat2_d9", 0, 0, 1, 1);
        apply_stimulus(4'd8, "sat2_d8", 0, 0, 1, 2);
        apply_stimulus(4'd7, "sat2_d7", 0, 0, 1, 3);
        apply_stimulus(4'd6, "sat2_d6", 0, 0, 1, 4);
        apply_stimulus(4'd5, "sat2_d5", 0, 0, 1, 4);
        apply_stimulus(KEY_ENTER, "sat2_opens", 1, 0, 0, 0);
        apply_stimulus(KEY_LOCK, "sat2_lock", 0, 0, 0, 0);

        // Asynchronous reset in the middle of an alarm restores the default password.
        apply_stimulus(KEY_ENTER, "empty_enter1", 0, 0, 1, 0);
        apply_stimulus(KEY_ENTER, "empty_enter2", 0, 0, 2, 0);
        apply_stimulus(KEY_ENTER, "empty_enter3", 0, 1, 3, 0);
        idle(5);
        #2;
        rst = 1'b1;
        #1;
        expect_out("async_reset", 0, 0, 0, 0);
        check_output();
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus(4'd9, "rst_d9", 0, 0, 0, 1);
        apply_stimulus(4'd8, "rst_d8", 0, 0, 0, 2);
        apply_stimulus(4'd7, "rst_d7", 0, 0, 0, 3);
        apply_stimulus(4'd6, "rst_d6", 0, 0, 0, 4);
        apply_stimulus(KEY_ENTER, "rst_old_pw_rejected", 0, 0, 1, 0);
        apply_stimulus(4'd1, "rst_d1", 0, 0, 1, 1);
        apply_stimulus(4'd2, "rst_d2", 0, 0, 1, 2);
        apply_stimulus(4'd3, "rst_d3", 0, 0, 1, 3);
        apply_stimulus(4'd4, "rst_d4", 0, 0, 1, 4);
        apply_stimulus(KEY_ENTER, "rst_default_opens", 1, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/safe_box_ctrl.md
SAFE_BOX_CTRL -- requirements
Module: safe_box_ctrl

Interface
REQ-001 Parameter DEF_PW, 16'h1234, power-on/reset password as four BCD digits, MSD first.
REQ-002 Parameter MAX_TRIES, 3, consecutive wrong attempts that trigger alarm.
REQ-003 Parameter ALARM_CYCLES, 500000, alarm lockout duration in clk cycles.
REQ-004 Parameter OPEN_TIMEOUT, 1000000, idle cycles in OPEN before auto-relock.
REQ-005 clk  in  1  system clock; all state changes on posedge clk.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 key_valid  in  1  single-cycle strobe, key_code valid when high.
REQ-008 key_code  in  4  0-9 digit; 4'hA ENTER; 4'hB CLEAR; 4'hC LOCK; 4'hD SETPW; others ignored.
REQ-009 state  out  1  1 = safe opened, 0 = locked; drives the matrix display stage.
REQ-010 alarm  out  1  high for the whole alarm lockout.
REQ-011 err_cnt  out  2  consecutive wrong attempts so far.
REQ-012 digit_cnt  out  3  digits held in the entry buffer, 0..4.

Function
REQ-013 FSM states SHALL be LOCKED, OPEN, SET_PW, ALARM; state output SHALL be 1 only in OPEN and SET_PW.
REQ-014 All outputs SHALL be registered; a key SHALL take effect on the posedge where key_valid=1, visible on outputs after that same edge.
REQ-015 Digit key in LOCKED or SET_PW SHALL shift into a 16-bit entry buffer (new digit in LSD) and increment digit_cnt; with digit_cnt=4 further digits SHALL be ignored.
REQ-016 CLEAR SHALL zero buffer and digit_cnt without changing err_cnt or FSM state.
REQ-017 ENTER in LOCKED with digit_cnt=4 and buffer=password SHALL go to OPEN, zero err_cnt, clear buffer.
REQ-018 ENTER in LOCKED otherwise (mismatch or digit_cnt<4) SHALL be a wrong attempt: err_cnt+1, buffer cleared, remain LOCKED.
REQ-019 Wrong attempt making err_cnt reach MAX_TRIES SHALL enter ALARM on that edge, alarm=1, err_cnt held at MAX_TRIES.
REQ-020 In ALARM all keys SHALL be ignored; after exactly ALARM_CYCLES cycles FSM SHALL return to LOCKED with alarm=0, err_cnt=0.
REQ-021 In OPEN, LOCK SHALL go to LOCKED; SETPW SHALL go to SET_PW with buffer cleared; digits and ENTER ignored.
REQ-022 In SET_PW, ENTER with digit_cnt=4 SHALL load buffer into the password register and return to OPEN; ENTER with digit_cnt<4 SHALL return to OPEN, password unchanged; LOCK SHALL go to LOCKED, password unchanged.
REQ-023 Idle counter SHALL reset on any key_valid in OPEN/SET_PW and on entry to them; reaching OPEN_TIMEOUT SHALL force LOCKED with buffer cleared.
REQ-024 LOCK/SETPW in LOCKED and CLEAR in ALARM SHALL be no-ops.

Reset
REQ-025 rst SHALL immediately force LOCKED, state=0, alarm=0, err_cnt=0, digit_cnt=0, buffer=0, counters=0, password=DEF_PW, regardless of current operation.

Structure
REQ-026 State encoding and key-code constants SHALL live in shared package safe_box_pkg.
REQ-027 Entry buffer and digit counter SHALL be one sub-module, pw_entry_buf (shift, clear, count, saturate); FSM, password register and timers remain in safe_box_ctrl.

Verification (ALARM_CYCLES=20, OPEN_TIMEOUT=50)
REQ-028 Reset, keys 1,2,3,4,ENTER -> state=1 after ENTER edge, err_cnt=0.
REQ-029 Keys 1,2,3,5,ENTER three times -> err_cnt 1,2 then alarm=1; digits ignored 20 cycles; then alarm=0, err_cnt=0, state=0.
REQ-030 Open, SETPW, 9,8,7,6,ENTER, LOCK, then 1,2,3,4,ENTER -> state=0, err_cnt=1; 9,8,7,6,ENTER -> state=1.
REQ-031 Open, no keys 50 cycles -> state=0; key at cycle 49 restarts count.
REQ-032 Keys 1,2,ENTER -> err_cnt=1; keys 1,2,3,4,5 -> digit_cnt=4, buffer 1234; CLEAR -> digit_cnt=0.
REQ-033 After password changed to 9876, assert rst mid-ALARM -> alarm=0 asynchronously; 1,2,3,4,ENTER opens.
